// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg
//   Shared encoding for the CPU control path: opcode values, state codes
//   and terminal-state set. Used by control_sequencer and by the control
//   output decoder, so both sides agree on every code.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    OP_LOAD = 4'd0, OP_MOVE = 4'd1, OP_LDPC = 4'd2, OP_BRANCH = 4'd3,
    OP_SUB  = 4'd4, OP_ADD  = 4'd5, OP_XOR  = 4'd6, OP_PUSH   = 4'd7,
    OP_POP  = 4'd8, OP_CALL = 4'd9, OP_RET  = 4'd10
  } opcode_e;

  typedef enum logic [7:0] {
    ST_IDLE   = 8'h00, ST_DECODE = 8'h01, ST_LOAD   = 8'h02, ST_MOVE   = 8'h03,
    ST_LDPC   = 8'h04, ST_BRANCH = 8'h05,
    ST_SUB0   = 8'h06, ST_SUB1   = 8'h07, ST_SUB2   = 8'h08,
    ST_ADD0   = 8'h09, ST_ADD1   = 8'h0A, ST_ADD2   = 8'h0B,
    ST_XOR0   = 8'h0C, ST_XOR1   = 8'h0D, ST_XOR2   = 8'h0E,
    ST_FETCH  = 8'h0F,
    ST_PUSH0  = 8'h13, ST_PUSH1  = 8'h14, ST_PUSH2  = 8'h15, ST_PUSH3  = 8'h16,
    ST_POP0   = 8'h17, ST_POP1   = 8'h18, ST_POP2   = 8'h19, ST_POP3   = 8'h1A,
    ST_CALL0  = 8'h1B, ST_CALL1  = 8'h1C, ST_CALL2  = 8'h1D, ST_CALL3  = 8'h1E,
    ST_CALL4  = 8'h1F, ST_CALL5  = 8'h20,
    ST_RET0   = 8'h21, ST_RET1   = 8'h22, ST_RET2   = 8'h23, ST_RET3   = 8'h24
  } state_e;

  // Opcodes 11..15 are unassigned.
  function automatic logic opcode_is_legal(input logic [3:0] op);
    return op <= 4'd10;
  endfunction

  // First execute state for an opcode; ST_IDLE for unassigned opcodes.
  function automatic state_e opcode_entry_state(input logic [3:0] op);
    case (op)
      OP_LOAD:   return ST_LOAD;
      OP_MOVE:   return ST_MOVE;
      OP_LDPC:   return ST_LDPC;
      OP_BRANCH: return ST_BRANCH;
      OP_SUB:    return ST_SUB0;
      OP_ADD:    return ST_ADD0;
      OP_XOR:    return ST_XOR0;
      OP_PUSH:   return ST_PUSH0;
      OP_POP:    return ST_POP0;
      OP_CALL:   return ST_CALL0;
      OP_RET:    return ST_RET0;
      default:   return ST_IDLE;
    endcase
  endfunction

  // Last execute state for an opcode; ST_IDLE for unassigned opcodes.
  function automatic state_e opcode_last_state(input logic [3:0] op);
    case (op)
      OP_LOAD:   return ST_LOAD;
      OP_MOVE:   return ST_MOVE;
      OP_LDPC:   return ST_LDPC;
      OP_BRANCH: return ST_BRANCH;
      OP_SUB:    return ST_SUB2;
      OP_ADD:    return ST_ADD2;
      OP_XOR:    return ST_XOR2;
      OP_PUSH:   return ST_PUSH3;
      OP_POP:    return ST_POP3;
      OP_CALL:   return ST_CALL5;
      OP_RET:    return ST_RET3;
      default:   return ST_IDLE;
    endcase
  endfunction

  function automatic logic is_terminal(input logic [7:0] s);
    case (s)
      ST_LOAD, ST_MOVE, ST_LDPC, ST_BRANCH, ST_SUB2, ST_ADD2, ST_XOR2,
      ST_PUSH3, ST_POP3, ST_CALL5, ST_RET3: return 1'b1;
      default:                              return 1'b0;
    endcase
  endfunction

  // Execute-phase codes: 0x02..0x0E and 0x13..0x24.
  function automatic logic is_exec_state(input logic [7:0] s);
    return (s >= 8'h02 && s <= 8'h0E) || (s >= 8'h13 && s <= 8'h24);
  endfunction

endpackage

// File: rtl/control_sequencer.sv
// control_sequencer
//   Microcode-style state sequencer: fetch (0x00 -> 0x0F -> 0x01), decode
//   dispatch by opcode, then a +1 walk through the execute states of that
//   instruction and back to 0x00.
// Ports
//   clk        in   system clock, rising edge
//   reset_n    in   synchronous active-low reset
//   run        in   level enable, only looked at in state 0x00
//   instr[15:0] in  instruction register, opcode in [15:12]
//   state[7:0] out  registered state code
//   busy       out  state != 0x00
//   instr_done out  one-cycle pulse on entry to 0x00 after a legal instruction
//   illegal    out  one-cycle pulse on entry to 0x00 after an unassigned opcode
//   retired[15:0] out count of completed legal instructions, wraps silently
module control_sequencer
  import cpu_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        run,
  input  logic [15:0] instr,
  output logic [7:0]  state,
  output logic        busy,
  output logic        instr_done,
  output logic        illegal,
  output logic [15:0] retired
);

  state_e      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic        done_d, ill_d;
  // Set by reset so the first edge after reset release stays in 0x00.
  logic        hold_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      op_q       <= 4'd0;
      instr_done <= 1'b0;
      illegal    <= 1'b0;
      retired    <= 16'd0;
      hold_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      instr_done <= done_d;
      illegal    <= ill_d;
      retired    <= retired + {15'd0, done_d};
      hold_q     <= 1'b0;
    end
  end

  always_comb begin
    state_d = ST_IDLE;
    op_d    = op_q;
    done_d  = 1'b0;
    ill_d   = 1'b0;
    case (state_q)
      ST_IDLE:   state_d = (run && !hold_q) ? ST_FETCH : ST_IDLE;
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: begin
        // Dispatch straight off instr; the captured copy drives execute.
        op_d = instr[15:12];
        if (opcode_is_legal(instr[15:12])) begin
          state_d = opcode_entry_state(instr[15:12]);
        end else begin
          ill_d = 1'b1;
        end
      end
      default: begin
        if (!is_exec_state(state_q)) begin
          state_d = ST_IDLE;
        end else if (is_terminal(state_q)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (state_q > opcode_last_state(op_q)) begin
          // Walked past the captured opcode's sequence: abandon, no retire.
          state_d = ST_IDLE;
        end else begin
          state_d = state_e'(state_q + 8'd1);
        end
      end
    endcase
  end

  assign state = state_q;
  assign busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: vector table plus hand-written
// latency, illegal-opcode and counter-wrap sequences.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        run = 1'b0;
  logic [15:0] instr = 16'h0000;
  logic [7:0]  state;
  logic        busy, instr_done, illegal;
  logic [15:0] retired;

  control_sequencer dut (
    .clk(clk), .reset_n(reset_n), .run(run), .instr(instr),
    .state(state), .busy(busy), .instr_done(instr_done),
    .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        run;
    logic [15:0] instr;
    logic [7:0]  st;
    logic        busy;
    logic        done;
    logic        ill;
    logic [15:0] ret;
  } vec_t;

  vec_t vecs[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  function automatic void add(input logic r, input logic rn, input logic [15:0] in,
                              input logic [7:0] st, input logic d, input logic il,
                              input logic [15:0] rt);
    vec_t v;
    v.rst_n = r; v.run = rn; v.instr = in; v.st = st;
    v.busy = (st != 8'h00); v.done = d; v.ill = il; v.ret = rt;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int lat_tab[11] = '{4, 4, 4, 4, 6, 6, 6, 7, 7, 9, 7};

  initial begin
    logic [15:0] exp_ret;
    int lat;

    // reset, then load
    add(0,0,16'h0000, 8'h00,0,0,0);
    add(1,1,16'h0120, 8'h00,0,0,0);   // held on first edge after reset
    add(1,1,16'h0120, 8'h0F,0,0,0);
    add(1,1,16'h0120, 8'h01,0,0,0);
    add(1,0,16'h0120, 8'h02,0,0,0);
    add(1,0,16'h0120, 8'h00,1,0,1);
    add(1,0,16'h0120, 8'h00,0,0,1);
    // back-to-back add, run held high
    add(1,1,16'h5230, 8'h0F,0,0,1);
    add(1,1,16'h5230, 8'h01,0,0,1);
    add(1,1,16'h5230, 8'h09,0,0,1);
    add(1,1,16'h5230, 8'h0A,0,0,1);
    add(1,1,16'h5230, 8'h0B,0,0,1);
    add(1,1,16'h5230, 8'h00,1,0,2);
    add(1,1,16'h5230, 8'h0F,0,0,2);   // no idle cycle
    add(1,1,16'h5230, 8'h01,0,0,2);
    add(1,1,16'h5230, 8'h09,0,0,2);
    add(1,1,16'h5230, 8'h0A,0,0,2);
    add(1,0,16'h5230, 8'h0B,0,0,2);
    add(1,0,16'h5230, 8'h00,1,0,3);
    add(1,0,16'h5230, 8'h00,0,0,3);
    // illegal opcode
    add(1,1,16'hF000, 8'h0F,0,0,3);
    add(1,0,16'hF000, 8'h01,0,0,3);
    add(1,0,16'hF000, 8'h00,0,1,3);
    add(1,0,16'hF000, 8'h00,0,0,3);
    // call then ret (run dropped during the instruction)
    add(1,1,16'h9000, 8'h0F,0,0,3);
    add(1,0,16'h9000, 8'h01,0,0,3);
    add(1,0,16'h9000, 8'h1B,0,0,3);
    add(1,0,16'h9000, 8'h1C,0,0,3);
    add(1,0,16'h9000, 8'h1D,0,0,3);
    add(1,0,16'h9000, 8'h1E,0,0,3);
    add(1,0,16'h9000, 8'h1F,0,0,3);
    add(1,0,16'h9000, 8'h20,0,0,3);
    add(1,0,16'h9000, 8'h00,1,0,4);
    add(1,1,16'hA000, 8'h0F,0,0,4);
    add(1,0,16'hA000, 8'h01,0,0,4);
    add(1,0,16'hA000, 8'h21,0,0,4);
    add(1,0,16'hA000, 8'h22,0,0,4);
    add(1,0,16'hA000, 8'h23,0,0,4);
    add(1,0,16'hA000, 8'h24,0,0,4);
    add(1,0,16'hA000, 8'h00,1,0,5);
    // sub
    add(1,1,16'h4000, 8'h0F,0,0,5);
    add(1,0,16'h4000, 8'h01,0,0,5);
    add(1,0,16'h4000, 8'h06,0,0,5);
    add(1,0,16'h4000, 8'h07,0,0,5);
    add(1,0,16'h4000, 8'h08,0,0,5);
    add(1,0,16'h4000, 8'h00,1,0,6);
    // push interrupted by reset at 0x15
    add(1,1,16'h7000, 8'h0F,0,0,6);
    add(1,0,16'h7000, 8'h01,0,0,6);
    add(1,0,16'h7000, 8'h13,0,0,6);
    add(1,0,16'h7000, 8'h14,0,0,6);
    add(1,0,16'h7000, 8'h15,0,0,6);
    add(0,0,16'h7000, 8'h00,0,0,0);
    add(1,1,16'h8000, 8'h00,0,0,0);   // held on first edge after reset
    add(1,1,16'h8000, 8'h0F,0,0,0);
    add(1,0,16'h8000, 8'h01,0,0,0);
    add(1,0,16'h8000, 8'h17,0,0,0);
    add(1,0,16'h8000, 8'h18,0,0,0);
    add(1,0,16'h8000, 8'h19,0,0,0);
    add(1,0,16'h8000, 8'h1A,0,0,0);
    add(1,0,16'h8000, 8'h00,1,0,1);
    add(1,0,16'h8000, 8'h00,0,0,1);

    foreach (vecs[i]) begin
      reset_n = vecs[i].rst_n;
      run     = vecs[i].run;
      instr   = vecs[i].instr;
      tick();
      chk($sformatf("v%0d state", i),   {24'd0, state},      {24'd0, vecs[i].st});
      chk($sformatf("v%0d busy", i),    {31'd0, busy},       {31'd0, vecs[i].busy});
      chk($sformatf("v%0d done", i),    {31'd0, instr_done}, {31'd0, vecs[i].done});
      chk($sformatf("v%0d illegal", i), {31'd0, illegal},    {31'd0, vecs[i].ill});
      chk($sformatf("v%0d retired", i), {16'd0, retired},    {16'd0, vecs[i].ret});
    end

    // Latency from leaving 0x00 to instr_done for every legal opcode.
    exp_ret = 16'd1;
    for (int op = 0; op <= 10; op++) begin
      run   = 1'b1;
      instr = {op[3:0], 12'h0AB};
      lat   = 0;
      for (int c = 1; c <= 20; c++) begin
        tick();
        run = 1'b0;
        if (instr_done === 1'b1) begin
          lat = c;
          break;
        end
      end
      exp_ret = exp_ret + 16'd1;
      chk($sformatf("op%0d latency", op), lat, lat_tab[op]);
      chk($sformatf("op%0d retired", op), {16'd0, retired}, {16'd0, exp_ret});
      tick();
      chk($sformatf("op%0d done pulse", op), {31'd0, instr_done}, 32'd0);
    end

    // Every unassigned opcode: illegal pulse, retired untouched.
    for (int op = 11; op <= 15; op++) begin
      run   = 1'b1;
      instr = {op[3:0], 12'h000};
      tick();
      run = 1'b0;
      tick();
      chk($sformatf("ill%0d decode", op), {24'd0, state}, 32'h01);
      tick();
      chk($sformatf("ill%0d state", op),   {24'd0, state},      32'h00);
      chk($sformatf("ill%0d pulse", op),   {31'd0, illegal},    32'd1);
      chk($sformatf("ill%0d done", op),    {31'd0, instr_done}, 32'd0);
      chk($sformatf("ill%0d retired", op), {16'd0, retired},    {16'd0, exp_ret});
      tick();
      chk($sformatf("ill%0d pulse end", op), {31'd0, illegal}, 32'd0);
    end

    // Counter wrap on a move.
    force dut.retired = 16'hFFFF;
    tick();
    release dut.retired;
    tick();
    chk("wrap preset", {16'd0, retired}, 32'h0000FFFF);
    run   = 1'b1;
    instr = 16'h1230;
    lat   = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      run = 1'b0;
      if (instr_done === 1'b1) begin
        lat = c;
        break;
      end
    end
    chk("wrap latency", lat, 4);
    chk("wrap retired", {16'd0, retired}, 32'h0);
    chk("wrap state",   {24'd0, state},   32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL expose port clk, input, 1, single system clock; all state changes on its rising edge.
REQ-002 SHALL expose port reset_n, input, 1, reset that is synchronous and active-low.
REQ-003 SHALL expose port run, input, 1, level enable; high allows a new fetch to start from state 0x00.
REQ-004 SHALL expose port instr, input, 16, instruction register contents; opcode in instr[15:12].
REQ-005 SHALL expose port state, output, 8, registered state code consumed by the control output decoder.
REQ-006 SHALL expose port busy, output, 1, high whenever state is not 0x00.
REQ-007 SHALL expose port instr_done, output, 1, one-cycle pulse on the cycle after the last execute state of a legal instruction.
REQ-008 SHALL expose port illegal, output, 1, one-cycle pulse on the cycle after decode of an unassigned opcode.
REQ-009 SHALL expose port retired, output, 16, count of completed legal instructions.

Function
REQ-010 SHALL run the fetch sequence 0x00 -> 0x0F -> 0x01, one cycle each; 0x00 holds while run=0 and leaves when run=1.
REQ-011 SHALL sample instr[15:12] only in state 0x01, capture it in an internal opcode register, and use only that register during the execute states.
REQ-012 SHALL dispatch from 0x01 by opcode: 0 load -> 0x02; 1 move -> 0x03; 2 ldpc -> 0x04; 3 branch -> 0x05; 4 sub -> 0x06; 5 add -> 0x09; 6 xor -> 0x0C; 7 push -> 0x13; 8 pop -> 0x17; 9 call -> 0x1B; 10 ret -> 0x21.
REQ-013 SHALL step multi-cycle sequences by +1 per cycle: sub 0x06-0x08, add 0x09-0x0B, xor 0x0C-0x0E, push 0x13-0x16, pop 0x17-0x1A, call 0x1B-0x20, ret 0x21-0x24.
REQ-014 SHALL go to 0x00 on the cycle after each terminal state (0x02, 0x03, 0x04, 0x05, 0x08, 0x0B, 0x0E, 0x16, 0x1A, 0x20, 0x24).
REQ-015 SHALL, in the same cycle it enters 0x00 from a terminal state, assert instr_done for that one cycle and increment retired by 1.
REQ-016 SHALL go from 0x01 to 0x00 on opcodes 11-15, pulse illegal for one cycle, and leave retired and instr_done unchanged.
REQ-017 SHALL give these total latencies from leaving 0x00 to instr_done:
- load, move, ldpc, branch: 4 cycles
- sub, add, xor: 6 cycles
- push, pop, ret: 7 cycles
- call: 9 cycles
REQ-018 SHALL wrap retired from 0xFFFF to 0x0000 with no flag.
REQ-019 SHALL ignore run outside state 0x00, so dropping run mid-instruction completes that instruction.
REQ-020 SHALL never drive a state code outside the set listed in REQ-010 to REQ-013; any other code reached SHALL go to 0x00 on the next edge.
REQ-021 SHALL start the next fetch with no idle cycle when run=1 in the 0x00 cycle entered after a terminal state.

Reset
REQ-022 SHALL, on any clk edge with reset_n=0, including mid-instruction, set:
- state to 0x00, busy to 0
- instr_done, illegal and retired to 0
- the opcode register to 0
REQ-023 SHALL hold fetch on the first edge after reset_n returns high; the sequencer resumes per REQ-010 from 0x00.

Structure
REQ-024 SHALL take all state codes, opcode values and terminal-state set from the shared package cpu_ctrl_pkg, which the control output decoder also uses.
REQ-025 SHALL be one module with no sub-module; the opcode-to-first-state mapping SHALL be a package function, opcode_entry_state.

Verification
REQ-026 SHALL cover load: reset, run=1, instr=0x0120 -> state 0x00, 0x0F, 0x01, 0x02, 0x00; instr_done pulses on entry to 0x00; retired=1.
REQ-027 SHALL cover back-to-back add: instr=0x5230 and run held high -> 0x01, 0x09, 0x0A, 0x0B, 0x00, 0x0F with no idle cycle; retired=1 after one add, 2 after two.
REQ-028 SHALL cover call then ret: instr=0x9000 -> states 0x1B to 0x20 then 0x00; then instr=0xA000 -> states 0x21 to 0x24 then 0x00; retired +2.
REQ-029 SHALL cover illegal opcode: instr=0xF000 -> 0x01 then 0x00, illegal=1 for one cycle, instr_done=0, retired unchanged.
REQ-030 SHALL cover reset mid-instruction: reset_n=0 while state=0x15 (push) -> next edge state=0x00, retired=0, busy=0.
REQ-031 SHALL cover counter wrap: force retired to 0xFFFF, complete a move (instr=0x1230) -> retired=0x0000, instr_done pulses.
